// File: rtl/apu_dispatcher.sv
// Purpose : APU request/response initiator; issues FP ops to the FPU and buffers results in order for writeback.
// Latency : issue accept -> apu_req_o next cycle; apu_rvalid_i -> wb_valid_o next cycle.
// Backpressure: issue stalls on missing grant or exhausted credits; the response channel is never stalled.
//
// Ports   : clk_i/rst_i (sync, active-high); issue_* (valid/ready from FC issue stage);
//           apu_* (req/gnt request channel with registered payload, rvalid response pulse);
//           wb_* (valid/ready in-order writeback heads); fflags_o/fflags_clr_i sticky status;
//           busy_o any op in flight; err_o sticky unexpected-response error.
// Option  : define APU_DISPATCH_FFLAGS_EN to build the sticky fflags_o accumulator;
//           otherwise fflags_o is tied to 0 and fflags_clr_i is ignored.

// Purpose : generic synchronous FIFO with simultaneous push/pop (also when full).
// Latency : push visible at rd_dat the cycle after the write; rd_dat is the head, not registered.
// Backpressure: wr_vld is dropped when full unless a pop happens in the same cycle.
module apu_dispatcher_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         wr_vld,
    input  logic [W-1:0] wr_dat,
    input  logic         rd_rdy,
    output logic [W-1:0] rd_dat,
    output logic         empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] LAST     = AW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [AW-1:0] PONE     = AW'(1);
    localparam logic [CW-1:0] CONE     = CW'(1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign do_pop  = rd_rdy && !empty;
    assign do_push = wr_vld && ((count != FULL_CNT) || do_pop);
    assign rd_dat  = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PONE;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CONE;
                2'b01:   count <= count - CONE;
                default: count <= count;
            endcase
        end
    end
endmodule

module apu_dispatcher #(
    parameter int NARGS           = 3,
    parameter int WOP             = 6,
    parameter int NDSFLAGS        = 15,
    parameter int NUSFLAGS        = 5,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  issue_valid_i,
    output logic                  issue_ready_o,
    input  logic [NARGS*32-1:0]   issue_operands_i,
    input  logic [WOP-1:0]        issue_op_i,
    input  logic [NDSFLAGS-1:0]   issue_flags_i,
    input  logic [4:0]            issue_rd_i,
    output logic                  apu_req_o,
    input  logic                  apu_gnt_i,
    output logic [NARGS*32-1:0]   apu_operands_o,
    output logic [WOP-1:0]        apu_op_o,
    output logic [NDSFLAGS-1:0]   apu_flags_o,
    input  logic                  apu_rvalid_i,
    input  logic [31:0]           apu_rdata_i,
    input  logic [NUSFLAGS-1:0]   apu_rflags_i,
    output logic                  wb_valid_o,
    input  logic                  wb_ready_i,
    output logic [4:0]            wb_rd_o,
    output logic [31:0]           wb_data_o,
    output logic [NUSFLAGS-1:0]   wb_flags_o,
    output logic [NUSFLAGS-1:0]   fflags_o,
    input  logic                  fflags_clr_i,
    output logic                  busy_o,
    output logic                  err_o
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int RW = 32 + NUSFLAGS;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);
    localparam logic [CW-1:0] ONE     = CW'(1);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;   // issued, not yet popped at writeback
    logic [CW-1:0] gcnt;  // granted, response not yet returned

    logic          issue_fire;
    logic          grant;
    logic          resp_ok;
    logic          wb_fire;
    logic          resp_empty;
    logic          rd_empty;
    logic [RW-1:0] resp_head;
    logic [4:0]    rd_head;

    // Grant frees the request slot in the same cycle, so a new op can follow
    // back-to-back. Held low during reset so nothing is accepted then.
    assign issue_ready_o = !rst_i && ((state == IDLE) || apu_gnt_i) && (cnt < MAX_CNT);
    assign issue_fire    = issue_valid_i && issue_ready_o;
    assign grant         = (state == REQ) && apu_gnt_i;
    // A response with nothing granted outstanding cannot belong to us; drop it.
    assign resp_ok       = apu_rvalid_i && (gcnt != '0);
    assign wb_fire       = wb_valid_o && wb_ready_i;

    // Request FSM and registered APU payload.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= IDLE;
            apu_req_o      <= 1'b0;
            apu_operands_o <= '0;
            apu_op_o       <= '0;
            apu_flags_o    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue_fire) begin
                        state          <= REQ;
                        apu_req_o      <= 1'b1;
                        apu_operands_o <= issue_operands_i;
                        apu_op_o       <= issue_op_i;
                        apu_flags_o    <= issue_flags_i;
                    end
                end
                REQ: begin
                    if (issue_fire) begin
                        // issue_fire in REQ implies grant: replace payload, stay in REQ
                        apu_operands_o <= issue_operands_i;
                        apu_op_o       <= issue_op_i;
                        apu_flags_o    <= issue_flags_i;
                    end else if (grant) begin
                        state     <= IDLE;
                        apu_req_o <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    apu_req_o <= 1'b0;
                end
            endcase
        end
    end

    // Credit and grant counters, sticky error.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt   <= '0;
            gcnt  <= '0;
            err_o <= 1'b0;
        end else begin
            case ({issue_fire, wb_fire})
                2'b10:   cnt <= cnt + ONE;
                2'b01:   cnt <= cnt - ONE;
                default: cnt <= cnt;
            endcase
            case ({grant, resp_ok})
                2'b10:   gcnt <= gcnt + ONE;
                2'b01:   gcnt <= gcnt - ONE;
                default: gcnt <= gcnt;
            endcase
            if (apu_rvalid_i && (gcnt == '0)) begin
                err_o <= 1'b1;
            end
        end
    end

    assign busy_o = (cnt != '0);

    // Destination registers in issue order; stays aligned with the response
    // FIFO because the APU returns results in order.
    apu_dispatcher_fifo #(
        .W     (5),
        .DEPTH (MAX_OUTSTANDING)
    ) u_rd_fifo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .wr_vld (issue_fire),
        .wr_dat (issue_rd_i),
        .rd_rdy (wb_fire),
        .rd_dat (rd_head),
        .empty  (rd_empty)
    );

    // Credits bound occupancy to MAX_OUTSTANDING, so a valid response always fits.
    apu_dispatcher_fifo #(
        .W     (RW),
        .DEPTH (MAX_OUTSTANDING)
    ) u_resp_fifo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .wr_vld (resp_ok),
        .wr_dat ({apu_rdata_i, apu_rflags_i}),
        .rd_rdy (wb_fire),
        .rd_dat (resp_head),
        .empty  (resp_empty)
    );

    logic unused_rd_empty;
    assign unused_rd_empty = rd_empty;

    // Heads are masked while empty so the writeback outputs read 0 out of reset.
    assign wb_valid_o = !resp_empty;
    assign wb_rd_o    = wb_valid_o ? rd_head : '0;
    assign wb_data_o  = wb_valid_o ? resp_head[RW-1:NUSFLAGS] : '0;
    assign wb_flags_o = wb_valid_o ? resp_head[NUSFLAGS-1:0] : '0;

`ifdef APU_DISPATCH_FFLAGS_EN
    // Clear wins over the old value, but a same-cycle response still lands.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fflags_o <= '0;
        end else if (fflags_clr_i) begin
            fflags_o <= resp_ok ? apu_rflags_i : '0;
        end else if (resp_ok) begin
            fflags_o <= fflags_o | apu_rflags_i;
        end
    end
`else
    assign fflags_o = '0;
    logic unused_fflags_clr;
    assign unused_fflags_clr = fflags_clr_i;
`endif
endmodule

// File: tb/tb_apu_dispatcher.sv
// Purpose : self-checking bench for apu_dispatcher against a queue-based reference model.
// Latency : one step per clock; inputs driven at negedge, outputs compared 1 time unit later.
// Backpressure: responder only answers granted ops, except one deliberately spurious pulse.
module tb_apu_dispatcher;
    localparam int NARGS = 3;
    localparam int WOP   = 6;
    localparam int NDS   = 15;
    localparam int NUS   = 5;
    localparam int MAXO  = 4;

    logic                clk_i = 1'b0;
    logic                rst_i;
    logic                issue_valid_i;
    logic                issue_ready_o;
    logic [NARGS*32-1:0] issue_operands_i;
    logic [WOP-1:0]      issue_op_i;
    logic [NDS-1:0]      issue_flags_i;
    logic [4:0]          issue_rd_i;
    logic                apu_req_o;
    logic                apu_gnt_i;
    logic [NARGS*32-1:0] apu_operands_o;
    logic [WOP-1:0]      apu_op_o;
    logic [NDS-1:0]      apu_flags_o;
    logic                apu_rvalid_i;
    logic [31:0]         apu_rdata_i;
    logic [NUS-1:0]      apu_rflags_i;
    logic                wb_valid_o;
    logic                wb_ready_i;
    logic [4:0]          wb_rd_o;
    logic [31:0]         wb_data_o;
    logic [NUS-1:0]      wb_flags_o;
    logic [NUS-1:0]      fflags_o;
    logic                fflags_clr_i;
    logic                busy_o;
    logic                err_o;

    apu_dispatcher #(
        .NARGS(NARGS), .WOP(WOP), .NDSFLAGS(NDS), .NUSFLAGS(NUS), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .issue_operands_i(issue_operands_i), .issue_op_i(issue_op_i),
        .issue_flags_i(issue_flags_i), .issue_rd_i(issue_rd_i),
        .apu_req_o(apu_req_o), .apu_gnt_i(apu_gnt_i),
        .apu_operands_o(apu_operands_o), .apu_op_o(apu_op_o), .apu_flags_o(apu_flags_o),
        .apu_rvalid_i(apu_rvalid_i), .apu_rdata_i(apu_rdata_i), .apu_rflags_i(apu_rflags_i),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_rd_o(wb_rd_o),
        .wb_data_o(wb_data_o), .wb_flags_o(wb_flags_o),
        .fflags_o(fflags_o), .fflags_clr_i(fflags_clr_i),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    // Reference model: an operation lives in rd_q from accept to pop; m_pend is
    // the op waiting for grant; m_g counts granted ops awaiting a response.
    bit                  m_pend;
    logic [NARGS*32-1:0] m_opnd;
    logic [WOP-1:0]      m_op;
    logic [NDS-1:0]      m_fl;
    logic [4:0]          m_rd_q [$];
    logic [31+NUS:0]     m_resp_q [$];
    int                  m_g;
    bit                  m_err;
    logic [NUS-1:0]      m_ff;
    logic [36:0]         got_q [$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        issue_valid_i    = 1'b0;
        issue_operands_i = '0;
        issue_op_i       = '0;
        issue_flags_i    = '0;
        issue_rd_i       = '0;
        apu_gnt_i        = 1'b0;
        apu_rvalid_i     = 1'b0;
        apu_rdata_i      = '0;
        apu_rflags_i     = '0;
        wb_ready_i       = 1'b0;
        fflags_clr_i     = 1'b0;
    endtask

    task automatic model_reset();
        m_pend = 0; m_opnd = '0; m_op = '0; m_fl = '0;
        m_rd_q.delete(); m_resp_q.delete();
        m_g = 0; m_err = 0; m_ff = '0;
    endtask

    // One clock: compare outputs against the model, then advance the model.
    task automatic step();
        logic exp_rdy;
        bit   fire, grant, rok, wbf;
        #1;
        exp_rdy = (!m_pend || apu_gnt_i) && (m_rd_q.size() < MAXO);
        if (!rst_i) begin
            check("issue_ready", issue_ready_o, exp_rdy);
            check("apu_req", apu_req_o, m_pend);
            check("apu_operands", apu_operands_o, m_opnd);
            check("apu_op", apu_op_o, m_op);
            check("apu_flags", apu_flags_o, m_fl);
            check("wb_valid", wb_valid_o, m_resp_q.size() != 0);
            if (m_resp_q.size() != 0) begin
                check("wb_rd", wb_rd_o, m_rd_q[0]);
                check("wb_data", wb_data_o, m_resp_q[0][31+NUS:NUS]);
                check("wb_flags", wb_flags_o, m_resp_q[0][NUS-1:0]);
            end
            check("busy", busy_o, m_rd_q.size() != 0);
            check("err", err_o, m_err);
`ifdef APU_DISPATCH_FFLAGS_EN
            check("fflags", fflags_o, m_ff);
`else
            check("fflags", fflags_o, 0);
`endif
            if (wb_valid_o && wb_ready_i) got_q.push_back({wb_rd_o, wb_data_o});
        end
        fire  = issue_valid_i && exp_rdy && !rst_i;
        grant = m_pend && apu_gnt_i;
        rok   = apu_rvalid_i && (m_g > 0);
        wbf   = (m_resp_q.size() != 0) && wb_ready_i;
        @(posedge clk_i);
        if (rst_i) begin
            model_reset();
        end else begin
            if (wbf) begin
                void'(m_rd_q.pop_front());
                void'(m_resp_q.pop_front());
            end
            if (fire) begin
                m_rd_q.push_back(issue_rd_i);
                m_opnd = issue_operands_i; m_op = issue_op_i; m_fl = issue_flags_i;
                m_pend = 1;
            end else if (grant) begin
                m_pend = 0;
            end
            if (apu_rvalid_i && m_g == 0) m_err = 1;
            if (fflags_clr_i) m_ff = rok ? apu_rflags_i : '0;
            else if (rok)     m_ff = m_ff | apu_rflags_i;
            if (rok) m_resp_q.push_back({apu_rdata_i, apu_rflags_i});
            m_g = m_g + int'(grant) - int'(rok);
        end
        @(negedge clk_i);
    endtask

    task automatic drain();
        int n = 0;
        while ((m_rd_q.size() != 0 || m_pend) && n < 300) begin
            idle();
            apu_gnt_i    = 1'($urandom_range(0, 1));
            apu_rvalid_i = (m_g > 0) && ($urandom_range(0, 1) == 1);
            apu_rdata_i  = $urandom;
            apu_rflags_i = NUS'($urandom);
            wb_ready_i   = 1'b1;
            step();
            n++;
        end
        idle();
        check("drain_busy", busy_o, 0);
    endtask

    task automatic issue_op(input logic [4:0] rd);
        issue_valid_i    = 1'b1;
        issue_operands_i = {$urandom, $urandom, $urandom};
        issue_op_i       = WOP'($urandom);
        issue_flags_i    = NDS'($urandom);
        issue_rd_i       = rd;
    endtask

    logic [31:0] res [3];
    logic [36:0] exp_e;
    int          ridx;

    initial begin
        res[0] = 32'hAAAA_0001; res[1] = 32'hBBBB_0002; res[2] = 32'hCCCC_0003;
        model_reset();
        idle();
        rst_i = 1'b1;
        @(negedge clk_i);
        step();
        step();
        rst_i = 1'b0;
        #1;
        check("rst_req", apu_req_o, 0);
        check("rst_ready", issue_ready_o, 1);
        check("rst_wb_valid", wb_valid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_err", err_o, 0);
        check("rst_fflags", fflags_o, 0);
        @(negedge clk_i);

        // Single operation.
        issue_valid_i    = 1'b1;
        issue_operands_i = {32'h3F80_0000, 32'h4000_0000, 32'h0};
        issue_op_i       = '0;
        issue_flags_i    = '0;
        issue_rd_i       = 5'd5;
        step();
        idle(); apu_gnt_i = 1'b1;
        step();
        idle(); step(); step();
        apu_rvalid_i = 1'b1; apu_rdata_i = 32'h4040_0000;
        step();
        idle();
        #1;
        check("single_wb_valid", wb_valid_o, 1);
        check("single_wb_rd", wb_rd_o, 5);
        check("single_wb_data", wb_data_o, 32'h4040_0000);
        @(negedge clk_i);
        wb_ready_i = 1'b1;
        step();
        idle();
        #1;
        check("single_busy_after_pop", busy_o, 0);
        @(negedge clk_i);

        // Credit limit with writeback stalled.
        for (int i = 0; i < 5; i++) begin
            issue_op(5'(i + 8));
            apu_gnt_i    = 1'b1;
            apu_rvalid_i = (m_g > 0);
            apu_rdata_i  = $urandom;
            step();
        end
        idle(); issue_valid_i = 1'b1; apu_gnt_i = 1'b1;
        #1;
        check("credit_ready_full", issue_ready_o, 0);
        @(negedge clk_i);
        idle();
        apu_rvalid_i = (m_g > 0);
        wb_ready_i   = 1'b1;
        step();
        idle();
        #1;
        check("credit_ready_after_pop", issue_ready_o, 1);
        @(negedge clk_i);
        drain();

        // In-order writeback with toggling ready.
        got_q.delete();
        ridx = 0;
        for (int k = 0; k < 16; k++) begin
            idle();
            if (k < 3) issue_op(5'(k + 1));
            apu_gnt_i = 1'b1;
            if (m_g > 0 && ridx < 3) begin
                apu_rvalid_i = 1'b1;
                apu_rdata_i  = res[ridx];
            end
            wb_ready_i = (k % 2) == 1;
            step();
            if (apu_rvalid_i) ridx++;
        end
        idle();
        check("inorder_count", got_q.size(), 3);
        for (int k = 0; k < 3; k++) begin
            exp_e = {5'(k + 1), res[k]};
            if (got_q.size() > k) check("inorder_entry", got_q[k], exp_e);
        end
        drain();

        // Sticky flags accumulate and clear.
        fflags_clr_i = 1'b1; step(); idle();
        issue_op(5'd1); step(); idle();
        apu_gnt_i = 1'b1; step(); idle();
        apu_rvalid_i = 1'b1; apu_rflags_i = 5'h01; step(); idle();
        issue_op(5'd2); step(); idle();
        apu_gnt_i = 1'b1; step(); idle();
        apu_rvalid_i = 1'b1; apu_rflags_i = 5'h10; step(); idle();
        #1;
`ifdef APU_DISPATCH_FFLAGS_EN
        check("fflags_accum", fflags_o, 5'h11);
`else
        check("fflags_accum", fflags_o, 5'h00);
`endif
        @(negedge clk_i);
        issue_op(5'd3); step(); idle();
        apu_gnt_i = 1'b1; step(); idle();
        apu_rvalid_i = 1'b1; apu_rflags_i = 5'h04; fflags_clr_i = 1'b1; step(); idle();
        #1;
`ifdef APU_DISPATCH_FFLAGS_EN
        check("fflags_clr_rvalid", fflags_o, 5'h04);
`else
        check("fflags_clr_rvalid", fflags_o, 5'h00);
`endif
        @(negedge clk_i);
        drain();

        // Randomized traffic.
        for (int c = 0; c < 1500; c++) begin
            idle();
            if ($urandom_range(0, 9) < 7) issue_op(5'($urandom));
            apu_gnt_i    = ($urandom_range(0, 9) < 6);
            apu_rvalid_i = (m_g > 0) && ($urandom_range(0, 1) == 1);
            apu_rdata_i  = $urandom;
            apu_rflags_i = NUS'($urandom);
            wb_ready_i   = ($urandom_range(0, 1) == 1);
            fflags_clr_i = ($urandom_range(0, 9) == 0);
            step();
        end
        drain();

        // Grant stall: request and payload hold, issue is blocked.
        issue_op(5'd7); step(); idle();
        for (int s = 0; s < 3; s++) begin
            issue_op(5'd9);
            step();
            #1;
            check("stall_ready", issue_ready_o, 0);
            check("stall_req", apu_req_o, 1);
            @(negedge clk_i);
        end
        idle(); apu_gnt_i = 1'b1; step(); idle();
        step();
        apu_rvalid_i = 1'b1; apu_rdata_i = 32'h1234_5678; step(); idle();
        wb_ready_i = 1'b1; step(); idle();
        // Only one grant was counted, so this second response is spurious.
        apu_rvalid_i = 1'b1; apu_rdata_i = 32'hDEAD_BEEF; step(); idle();
        #1;
        check("spurious_err", err_o, 1);
        check("spurious_no_push", wb_valid_o, 0);
        @(negedge clk_i);
        step();
        #1;
        check("spurious_err_sticky", err_o, 1);
        @(negedge clk_i);

        // Reset while a request is pending.
        issue_op(5'd4); step(); idle();
        rst_i = 1'b1; step(); rst_i = 1'b0;
        #1;
        check("rst_mid_req", apu_req_o, 0);
        check("rst_mid_busy", busy_o, 0);
        check("rst_mid_err", err_o, 0);
        check("rst_mid_wb_valid", wb_valid_o, 0);
        check("rst_mid_ready", issue_ready_o, 1);
        @(negedge clk_i);
        issue_op(5'd6); step(); idle();
        drain();
        check("final_err", err_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
